// File: rtl/tanh.sv
// Piecewise-linear tanh activation, signed Q8.8 in and out, one register of
// latency. The positive half p(|x|) is built from shifts, adds and compares,
// then negated for negative inputs so the result is exactly odd-symmetric.
//
// Handshake: in_valid qualifies `in` on a rising edge; there is no ready, so
// every qualified sample is accepted. out_valid is high for exactly the cycle
// after a sample is accepted, and `out` holds its last value while it is low.
module tanh (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in,
  output logic        out_valid,
  output logic [15:0] out
);

  // Segment breakpoints on the 17-bit magnitude.
  localparam logic [16:0] BP_LIN = 17'h00080;  // 0.5
  localparam logic [16:0] BP_MID = 17'h00133;  // ~1.2
  localparam logic [16:0] BP_SAT = 17'h00268;  // ~2.406

  logic        neg;
  logic [16:0] mag;
  logic [15:0] pos;
  logic [15:0] y;

  // Magnitude is 17 bits wide so that x = 0x8000 gives 0x08000 without wrapping.
  always_comb begin
    neg = in[15];
    mag = {in[15], in};
    if (neg) begin
      mag = 17'd0 - {in[15], in};
    end
  end

  // Positive-half segment selection; every shift truncates the magnitude.
  always_comb begin
    pos = 16'h0100;
    if (mag <= BP_LIN) begin
      pos = mag[15:0];
    end else if (mag <= BP_MID) begin
      pos = {1'b0, mag[15:1]} + 16'h0040;
    end else if (mag < BP_SAT) begin
      pos = {3'b000, mag[15:3]} + 16'h00B3;
    end
  end

  // Apply the sign after truncation so f(-x) = -f(x).
  always_comb begin
    y = pos;
    if (neg) begin
      y = 16'd0 - pos;
    end
  end

  // Single pipeline register; a bubble drops out_valid and holds out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= 16'h0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= y;
      end
    end
  end

endmodule

// File: tb/tb_tanh.sv
// Directed bench for the tanh activation unit: reset behaviour, a table of
// hand-computed vectors, a +/-4.0 sweep against a reference formula and a
// bubble sequence.
module tb_tanh;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in;
  logic        out_valid;
  logic [15:0] out;

  int n_cmp;
  int n_fail;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          tol;
  } vec_t;

  vec_t vecs[18];

  tanh dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference formula on plain integers.
  function automatic logic [15:0] golden(input logic [15:0] x);
    int a;
    int p;
    int yv;
    a = int'(x);
    if (x[15]) a = 65536 - a;
    if (a <= 128)      p = a;
    else if (a <= 307) p = a / 2 + 64;
    else if (a < 616)  p = a / 8 + 179;
    else               p = 256;
    yv = x[15] ? -p : p;
    return 16'(yv);
  endfunction

  task automatic check_val(input string name, input logic [15:0] act,
                           input logic [15:0] exp, input int tol);
    int d;
    d = int'($signed(act)) - int'($signed(exp));
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Driver: present one input, clock it in, then settle past the edge.
  task automatic apply(input logic v, input logic [15:0] x);
    in_valid = v;
    in       = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] e;
    int          x;
    int          step;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{16'h0000, 16'h0000, 0};
    vecs[1]  = '{16'h0066, 16'h0066, 0};
    vecs[2]  = '{16'h0080, 16'h0080, 0};
    vecs[3]  = '{16'h0099, 16'h008C, 0};
    vecs[4]  = '{16'h0100, 16'h00C0, 0};
    vecs[5]  = '{16'h0133, 16'h00D9, 0};
    vecs[6]  = '{16'h014C, 16'h00DC, 0};
    vecs[7]  = '{16'h0200, 16'h00F3, 0};
    vecs[8]  = '{16'h024C, 16'h00FC, 0};
    vecs[9]  = '{16'h0266, 16'h0100, 1};
    vecs[10] = '{16'h0280, 16'h0100, 0};
    vecs[11] = '{16'h7FFF, 16'h0100, 0};
    vecs[12] = '{16'hFF80, 16'hFF80, 0};
    vecs[13] = '{16'hFF00, 16'hFF40, 0};
    vecs[14] = '{16'hFE00, 16'hFF0D, 0};
    vecs[15] = '{16'hFD9A, 16'hFF00, 1};
    vecs[16] = '{16'hFC00, 16'hFF00, 0};
    vecs[17] = '{16'h8000, 16'hFF00, 0};

    // Power-on reset, asserted without any clock edge.
    rst      = 1'b1;
    in_valid = 1'b0;
    in       = 16'h0000;
    #2;
    check_val("reset_out", out, 16'h0000, 0);
    check_bit("reset_valid", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table vectors, each checked one cycle after issue.
    for (int i = 0; i < 18; i++) begin
      apply(1'b1, vecs[i].x);
      check_val($sformatf("vec_%04h", vecs[i].x), out, vecs[i].y, vecs[i].tol);
      check_bit($sformatf("vec_valid_%0d", i), out_valid, 1'b1);
    end

    // Asynchronous reset mid-stream with a valid sample on the input.
    apply(1'b1, 16'h0100);
    check_val("pre_rst_out", out, 16'h00C0, 0);
    in_valid = 1'b1;
    in       = 16'h0200;
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_out", out, 16'h0000, 0);
    check_bit("async_rst_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_val("rst_held_out", out, 16'h0000, 0);
    check_bit("rst_held_valid", out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 16'h0200);
    check_val("post_rst_out", out, 16'h00F3, 0);
    check_bit("post_rst_valid", out_valid, 1'b1);

    // Sweep -4.0 .. +4.0, valid held high, scoreboarded against the formula.
    x    = -1024;
    step = 0;
    prev = 16'h8000;
    while (x <= 1024) begin
      exp_q.push_back(golden(16'(x)));
      apply(1'b1, 16'(x));
      e = exp_q.pop_front();
      check_val($sformatf("sweep_%0d", x), out, e, 1);
      check_bit($sformatf("sweep_valid_%0d", x), out_valid, 1'b1);
      n_cmp++;
      if ($signed(out) < $signed(prev)) begin
        n_fail++;
        $display("FAIL sweep_mono_%0d: got 0x%04h after 0x%04h, expected non-decreasing",
                 x, out, prev);
      end
      prev = out;
      x    = x + ((step % 2 == 0) ? 26 : 25);
      step++;
    end

    // Bubble: valid 1,0,1; out holds across the gap.
    apply(1'b1, 16'h0100);
    check_val("bub0_out", out, 16'h00C0, 0);
    check_bit("bub0_valid", out_valid, 1'b1);
    apply(1'b0, 16'h0300);
    check_val("bub1_hold", out, 16'h00C0, 0);
    check_bit("bub1_valid", out_valid, 1'b0);
    apply(1'b1, 16'hFF00);
    check_val("bub2_out", out, 16'hFF40, 0);
    check_bit("bub2_valid", out_valid, 1'b1);
    apply(1'b0, 16'h0000);
    check_bit("bub3_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tanh.md
# tanh

Fixed-point hyperbolic-tangent activation unit for the RNN accelerator datapath. It takes one signed Q8.8 sample per clock and returns a piecewise-linear (PWL) approximation of tanh(x), also in signed Q8.8. The output is odd-symmetric and saturates to ±1.0. It sits after the gate accumulators in the RNN cell and is registered, with one cycle of latency.

## Interface
- No parameters. Formats are fixed: 16-bit two's complement, 8 integer bits and 8 fractional bits (1.0 = 0x0100).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies `in` on this clock edge.
- in  input  16  signed Q8.8 operand x.
- out_valid  output  1  `out` holds a result for the sample accepted one cycle earlier.
- out  output  16  signed Q8.8 result y ≈ tanh(x).

## Operation
- Form the magnitude a = |x| as a 17-bit unsigned value, so x = 0x8000 is handled without overflow. Compute the positive-half result p(a), then set y = −p if x < 0, otherwise y = p.
- p(a), with all shifts as logical right shifts that truncate the magnitude:
  - a ≤ 0x0080 (0.5): p = a (identity).
  - 0x0080 < a ≤ 0x0133 (≈1.2): p = (a >> 1) + 0x0040.
  - 0x0133 < a < 0x0268 (≈2.406): p = (a >> 3) + 0x00B3.
  - a ≥ 0x0268: p = 0x0100 (saturate to 1.0).
- The segments meet at the breakpoints, with a jump of at most 1 LSB. p is monotonic non-decreasing and never exceeds 0x0100.
- Negation is applied to the truncated magnitude, so the result is exactly odd-symmetric: f(−x) = −f(x) for every x ≠ 0x8000.
- f(0x8000) = 0xFF00.
- Accuracy contract: |y − golden| ≤ 1 LSB over all inputs, where golden is the segment formula above. Any implementation (mux tree or adders) that meets this is compliant.
- The datapath is pure shift, add and compare. No multipliers and no ROM.

## Timing
- Single pipeline register. When in_valid = 1 at edge N, `out` and out_valid = 1 are presented after edge N and remain until edge N+1.
- When in_valid = 0 at an edge, out_valid goes to 0 and `out` holds its previous value.
- Full throughput: one sample per cycle and no stall input. Back-to-back valid samples produce back-to-back results in order.
- Reset is asynchronous: asserting rst immediately forces out = 0x0000 and out_valid = 0, independent of clk.
- A sample accepted in the same cycle that rst asserts is discarded.
- The first edge after rst deasserts samples `in` normally.
- No combinational path from the inputs to the outputs.

## Test plan
- Reset: assert rst mid-stream with in_valid = 1 and in = 0x0200 → out = 0x0000 and out_valid = 0 immediately, with no clock edge needed. Release rst → the next valid sample appears one cycle later.
- Linear and mid segments, one sample per cycle:
  - 0x0000 → 0x0000
  - 0x0066 → 0x0066
  - 0x0080 → 0x0080
  - 0x0099 → 0x008C
  - 0x0100 → 0x00C0
  - 0x0133 → 0x00D9
  - Each is checked one cycle after issue with out_valid = 1.
- Tail and saturation:
  - 0x014C → 0x00DC
  - 0x0200 → 0x00F3
  - 0x024C → 0x00FC
  - 0x0266 → 0x00FF or 0x0100
  - 0x0280 → 0x0100
  - 0x7FFF → 0x0100
- Negative symmetry:
  - 0xFF80 → 0xFF80
  - 0xFF00 → 0xFF40
  - 0xFE00 → 0xFF0D
  - 0xFD9A → 0xFF00 (±1 LSB)
  - 0xFC00 → 0xFF00
  - 0x8000 → 0xFF00
- Sweep: x from −4.0 to +4.0 in steps of 0x001A / 0x0019 (≈0.1), with in_valid held high → each output is within 1 LSB of the golden formula, monotonic across the sweep, and out_valid stays high throughout.
- Bubbles: toggle in_valid as 1,0,1 with inputs 0x0100, 0x0300, 0xFF00 → out_valid sequence 1,0,1, outputs 0x00C0 then 0xFF40, and `out` holds 0x00C0 during the bubble.
